inst_queue: RTL
===============

# inst_queue

Front-end fetch unit and instruction queue that produces the `valid`/`pc`/`inst` stream consumed by the decoder. It issues one-word fetch requests to the memory/cache port, applies static next-PC prediction, and buffers fetched instructions in a circular FIFO. It pops one entry per decoder acceptance and is flushed by the ROB on misprediction.

## Interface
- `QUEUE_DEPTH`, 16: number of FIFO entries; must be a power of two.
- `QUEUE_BIT`, 4: log2(QUEUE_DEPTH), used for the head/tail pointer width.

Ports:
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `rdy_in` input 1: pause when low; all state holds.
- `fetch_req` output 1: fetch request, held high until `fetch_done`.
- `fetch_addr` output 32: word address of the outstanding request.
- `fetch_done` input 1: one-cycle response strobe.
- `fetch_data` input 32: instruction word, valid with `fetch_done`.
- `valid` output 1: the head entry is present.
- `pc` output 32: PC of the head entry.
- `inst` output 32: instruction word of the head entry.
- `pred_taken` output 1: predicted-taken bit for the head entry; forwarded to the ROB guess.
- `dec_taken` input 1: the decoder consumed the head this cycle.
- `rob_clear` input 1: flush pulse.
- `rob_target_pc` input 32: restart PC, valid with `rob_clear`.

## Operation
- **Storage:** per-entry `pc`, `inst` and `guess` arrays. Also `head`, `tail` (QUEUE_BIT wide, wrap modulo depth), a `count` register QUEUE_BIT+1 wide, and a 32-bit `fetch_pc`.
- **Fetch FSM states:**
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding, response to be discarded.
- **Transitions:**
  - IDLE→WAIT when `count < QUEUE_DEPTH` and no `rob_clear`. On this edge `fetch_req<=1` and `fetch_addr<=fetch_pc`.
  - WAIT→IDLE on `fetch_done`. On this edge:
    - write `{fetch_addr, fetch_data, guess}` at `tail`;
    - `tail++`;
    - `fetch_pc<=next_pc`;
    - `fetch_req<=0`.
  - WAIT→DROP on `rob_clear` without `fetch_done`.
  - DROP→IDLE on `fetch_done`; the data is discarded and `fetch_req<=0`.
- **Only one request is ever outstanding.** The space check at issue is therefore sufficient, because `count` can only rise through this unit's own fetch.
- **Prediction.** Opcode is `fetch_data[6:0]`; `p` = `fetch_addr`.
  - JAL (1101111): `next_pc = p + imm_j`, guess 0.
  - Branch (1100011) with `inst[31]=1` (backward): `next_pc = p + imm_b`, guess 1.
  - Forward branch: `p+4`, guess 0.
  - JALR and all other opcodes: `p+4`, guess 0.
  - `imm_j` and `imm_b` are the standard RV32I sign-extended immediates; all adds are 32-bit with wrap.
- **Output drive.**
  - `valid = (count != 0)`.
  - `pc`, `inst` and `pred_taken` read the arrays at `head`, and are forced to 0 when `count == 0`.
- **Pop.** On `valid && dec_taken`: `head++`, `count--`.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance. Pushing while full cannot occur.
- **Flush** (`rob_clear` with `rdy_in` high) has priority over everything:
  - `head = tail = count = 0` and `fetch_pc <= rob_target_pc`;
  - `dec_taken` in the same cycle is ignored;
  - a `fetch_done` in the same cycle while in WAIT is discarded and the FSM goes to IDLE (not DROP);
  - a flush in DROP stays in DROP and `fetch_pc` updates;
  - a flush in IDLE stays in IDLE.
- **Pause.** With `rdy_in` low, no register changes and `fetch_done`, `dec_taken` and `rob_clear` are ignored. The memory side is paused by the same `rdy_in`.

## Timing
- **Reset** (asynchronous, active-high) sets: `fetch_req=0`, `fetch_addr=0`, `valid=0`, `pc=0`, `inst=0`, `pred_taken=0`, `fetch_pc=0`, FSM=IDLE, `head=tail=count=0`.
  - Reset asserted mid-request abandons the request. Any `fetch_done` arriving afterwards while in IDLE is ignored.
- **Request latency:** `fetch_req` rises on the first edge after reset deassertion (queue empty).
- **Fill latency:** an entry written on the `fetch_done` edge drives `valid=1` in the following cycle.
- **Throughput:** at most one fetch per 2 cycles plus memory latency. The IDLE cycle between requests is mandatory.
- **Flush latency:** `valid` is 0 in the cycle after the flush edge. The next request, to `rob_target_pc`, is issued on the following edge from IDLE, or after the discarded response if in DROP.
- **Pop is same-cycle:** decoder acceptance at edge N makes the next entry visible in cycle N+1.

## Test plan
- **Straight-line fetch:** after reset, memory answers 3 cycles after each request. Required:
  - `fetch_addr` sequence 0, 4, 8;
  - `valid` rises with `pc=0`;
  - with `dec_taken` tied to `valid`, entries are popped in order.
- **Fill to full:** hold `dec_taken=0` and supply 17 responses' worth of requests. Required:
  - exactly 16 requests issued, then `fetch_req` stays 0;
  - one pop triggers exactly one more request.
- **Prediction:** `fetch_data=0x0080006F` (JAL +8) at pc 0x100 → next `fetch_addr=0x108`, `pred_taken=0`. `0xFE000EE3` (beq −4) at 0x200 → next 0x1FC, `pred_taken=1`.
- **Flush during WAIT:** assert `rob_clear` with `rob_target_pc=0x40` while a response is pending. Required:
  - the response is discarded;
  - `valid=0`;
  - the next request goes to 0x40.
- **Flush colliding with `fetch_done` and `dec_taken` in the same cycle:** queue ends empty, FSM is IDLE, the next request goes to the target.
- **Pause:** `rdy_in` low for 5 cycles with `dec_taken=1` and `fetch_done=1`. Required: no pointer or count change, outputs stable, normal operation resumes when `rdy_in` returns high.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: front-end fetch unit and circular instruction queue.
// Issues one-word fetches, applies static next-PC prediction and buffers
// {pc, inst, guess} entries for the decoder. Flushed by the ROB.
module inst_queue #(
  parameter int QUEUE_DEPTH = 16,
  parameter int QUEUE_BIT   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_done,
  input  logic [31:0] fetch_data,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        pred_taken,
  input  logic        dec_taken,
  input  logic        rob_clear,
  input  logic [31:0] rob_target_pc
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t               r_state;
  logic [31:0]          r_pc_q    [QUEUE_DEPTH];
  logic [31:0]          r_inst_q  [QUEUE_DEPTH];
  logic                 r_guess_q [QUEUE_DEPTH];
  logic [QUEUE_BIT-1:0] r_head;
  logic [QUEUE_BIT-1:0] r_tail;
  logic [QUEUE_BIT:0]   r_count;
  logic [31:0]          r_fetch_pc;

  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;
  logic [31:0] w_next_pc;
  logic        w_guess;
  logic        w_push;
  logic        w_pop;

  // RV32I J- and B-type immediates, sign-extended
  assign w_imm_j = {{11{fetch_data[31]}}, fetch_data[31], fetch_data[19:12],
                    fetch_data[20], fetch_data[30:21], 1'b0};
  assign w_imm_b = {{19{fetch_data[31]}}, fetch_data[31], fetch_data[7],
                    fetch_data[30:25], fetch_data[11:8], 1'b0};

  // Static prediction: JAL always redirects, backward branches predicted taken
  always_comb begin
    w_next_pc = fetch_addr + 32'd4;
    w_guess   = 1'b0;
    if (fetch_data[6:0] == OP_JAL) begin
      w_next_pc = fetch_addr + w_imm_j;
    end else if (fetch_data[6:0] == OP_BRANCH && fetch_data[31]) begin
      w_next_pc = fetch_addr + w_imm_b;
      w_guess   = 1'b1;
    end
  end

  // Queue occupancy; a full queue means count MSB set (depth is a power of two)
  assign valid  = (r_count != '0);
  assign w_push = rdy_in && !rob_clear && (r_state == S_WAIT) && fetch_done;
  assign w_pop  = rdy_in && !rob_clear && valid && dec_taken;

  assign pc         = valid ? r_pc_q[r_head]    : 32'd0;
  assign inst       = valid ? r_inst_q[r_head]  : 32'd0;
  assign pred_taken = valid ? r_guess_q[r_head] : 1'b0;

  // Entry storage: written only when a live response lands at the tail
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_pc_q[r_tail]    <= fetch_addr;
      r_inst_q[r_tail]  <= fetch_data;
      r_guess_q[r_tail] <= w_guess;
    end
  end

  // Fetch FSM with registered request outputs, plus pointers and fetch PC
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      fetch_req  <= 1'b0;
      fetch_addr <= 32'd0;
      r_fetch_pc <= 32'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= rob_target_pc;
        case (r_state)
          S_WAIT: begin
            // a response landing with the flush is simply dropped
            if (fetch_done) begin
              r_state   <= S_IDLE;
              fetch_req <= 1'b0;
            end else begin
              r_state <= S_DROP;
            end
          end
          S_DROP: begin
            if (fetch_done) begin
              r_state   <= S_IDLE;
              fetch_req <= 1'b0;
            end
          end
          default: ;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            // only one request in flight, so space checked here cannot vanish
            if (!r_count[QUEUE_BIT]) begin
              r_state    <= S_WAIT;
              fetch_req  <= 1'b1;
              fetch_addr <= r_fetch_pc;
            end
          end
          S_WAIT: begin
            if (fetch_done) begin
              r_state    <= S_IDLE;
              fetch_req  <= 1'b0;
              r_tail     <= r_tail + 1'b1;
              r_fetch_pc <= w_next_pc;
            end
          end
          S_DROP: begin
            if (fetch_done) begin
              r_state   <= S_IDLE;
              fetch_req <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            fetch_req <= 1'b0;
          end
        endcase
        if (w_pop) r_head <= r_head + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
